// File: rtl/map_bus_pkg.sv
// Shared types and constants for cartridge mapper channel selection.
// Idle bus values are what the shared buses carry when no channel owns them.
package map_bus_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } arb_state_e;

    localparam logic [7:0] DI_IDLE         = 8'h00;
    localparam logic       IRQ_N_IDLE      = 1'b1;
    localparam logic       ROM_CE_N_IDLE   = 1'b1;
    localparam logic       ROM_OE_N_IDLE   = 1'b1;
    localparam logic       ROM_WORD_IDLE   = 1'b0;
    localparam logic [7:0] BSRAM_D_IDLE    = 8'h00;
    localparam logic       BSRAM_CE_N_IDLE = 1'b1;
    localparam logic       BSRAM_OE_N_IDLE = 1'b1;
    localparam logic       BSRAM_WE_N_IDLE = 1'b1;

    // Width of a channel index covering channels 0..num_map.
    function automatic int sel_width(input int num_map);
        return (num_map < 2) ? 1 : $clog2(num_map + 1);
    endfunction

endpackage

// File: rtl/map_onehot_decode.sv
// Decodes the per-mapper active bits into a channel candidate.
// cand is only meaningful when multi is low; channel 0 is reported when none is set.
module map_onehot_decode
    import map_bus_pkg::*;
#(
    parameter int NUM_MAP = 4,
    parameter int SEL_W   = sel_width(NUM_MAP)
) (
    input  logic [NUM_MAP-1:0] map_active,
    output logic [SEL_W-1:0]   cand,
    output logic               multi,
    output logic               none
);

    logic seen;

    always_comb begin
        cand  = '0;
        multi = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < NUM_MAP; i++) begin
            if (map_active[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
                cand = SEL_W'(i + 1);
            end
        end
        if (multi) begin
            cand = '0;
        end
        none = ~seen;
    end

endmodule

// File: rtl/map_bus_arbiter.sv
// Routes one mapper channel onto the shared CPU/ROM/BSRAM buses with registered outputs.
// A selection change idles every bus for DRAIN_CYC cycles before the new channel takes over.
module map_bus_arbiter
    import map_bus_pkg::*;
#(
    parameter int NUM_MAP   = 4,
    parameter int ROM_AW    = 23,
    parameter int BSRAM_AW  = 20,
    parameter int DRAIN_CYC = 4
) (
    input  logic                              mclk,
    input  logic                              rst_n,
    input  logic [NUM_MAP-1:0]                map_active,
    input  logic [8*(NUM_MAP+1)-1:0]          ch_do,
    input  logic [NUM_MAP:0]                  ch_irq_n,
    input  logic [ROM_AW*(NUM_MAP+1)-1:0]     ch_rom_addr,
    input  logic [NUM_MAP:0]                  ch_rom_ce_n,
    input  logic [NUM_MAP:0]                  ch_rom_oe_n,
    input  logic [NUM_MAP:0]                  ch_rom_word,
    input  logic [BSRAM_AW*(NUM_MAP+1)-1:0]   ch_bsram_addr,
    input  logic [8*(NUM_MAP+1)-1:0]          ch_bsram_d,
    input  logic [NUM_MAP:0]                  ch_bsram_ce_n,
    input  logic [NUM_MAP:0]                  ch_bsram_oe_n,
    input  logic [NUM_MAP:0]                  ch_bsram_we_n,
    output logic [7:0]                        di,
    output logic                              irq_n,
    output logic [ROM_AW-1:0]                 rom_addr,
    output logic                              rom_ce_n,
    output logic                              rom_oe_n,
    output logic                              rom_word,
    output logic [BSRAM_AW-1:0]               bsram_addr,
    output logic [7:0]                        bsram_d,
    output logic                              bsram_ce_n,
    output logic                              bsram_oe_n,
    output logic                              bsram_we_n,
    output logic [sel_width(NUM_MAP)-1:0]     sel_idx,
    output logic                              switching,
    output logic                              onehot_err,
    output arb_state_e                        dbg_state
);

    localparam int NCH   = NUM_MAP + 1;
    localparam int SEL_W = sel_width(NUM_MAP);
    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DRAIN_CYC - 1);

    arb_state_e         state_q, state_d;
    logic [SEL_W-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_d;
    logic               switching_d;
    logic               load_bus;

    logic [SEL_W-1:0]   dec_cand;
    logic               multi;
    logic               none;
    logic [SEL_W-1:0]   cand;

    logic [7:0]          sel_do;
    logic                sel_irq_n;
    logic [ROM_AW-1:0]   sel_rom_addr;
    logic                sel_rom_ce_n;
    logic                sel_rom_oe_n;
    logic                sel_rom_word;
    logic [BSRAM_AW-1:0] sel_bsram_addr;
    logic [7:0]          sel_bsram_d;
    logic                sel_bsram_ce_n;
    logic                sel_bsram_oe_n;
    logic                sel_bsram_we_n;

    map_onehot_decode #(
        .NUM_MAP (NUM_MAP),
        .SEL_W   (SEL_W)
    ) u_decode (
        .map_active (map_active),
        .cand       (dec_cand),
        .multi      (multi),
        .none       (none)
    );

    // An ambiguous request keeps the committed channel rather than guessing.
    always_comb begin
        if (none) begin
            cand = '0;
        end else if (multi) begin
            cand = sel_idx;
        end else begin
            cand = dec_cand;
        end
    end

    always_comb begin
        sel_do         = DI_IDLE;
        sel_irq_n      = IRQ_N_IDLE;
        sel_rom_addr   = '0;
        sel_rom_ce_n   = ROM_CE_N_IDLE;
        sel_rom_oe_n   = ROM_OE_N_IDLE;
        sel_rom_word   = ROM_WORD_IDLE;
        sel_bsram_addr = '0;
        sel_bsram_d    = BSRAM_D_IDLE;
        sel_bsram_ce_n = BSRAM_CE_N_IDLE;
        sel_bsram_oe_n = BSRAM_OE_N_IDLE;
        sel_bsram_we_n = BSRAM_WE_N_IDLE;
        for (int c = 0; c < NCH; c++) begin
            if (sel_idx == SEL_W'(c)) begin
                sel_do         = ch_do[8*c +: 8];
                sel_irq_n      = ch_irq_n[c];
                sel_rom_addr   = ch_rom_addr[ROM_AW*c +: ROM_AW];
                sel_rom_ce_n   = ch_rom_ce_n[c];
                sel_rom_oe_n   = ch_rom_oe_n[c];
                sel_rom_word   = ch_rom_word[c];
                sel_bsram_addr = ch_bsram_addr[BSRAM_AW*c +: BSRAM_AW];
                sel_bsram_d    = ch_bsram_d[8*c +: 8];
                sel_bsram_ce_n = ch_bsram_ce_n[c];
                sel_bsram_oe_n = ch_bsram_oe_n[c];
                sel_bsram_we_n = ch_bsram_we_n[c];
            end
        end
    end

    // A request arriving mid-drain restarts the full window; returning to the old channel does not cancel it.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        sel_d       = sel_idx;
        switching_d = switching;
        load_bus    = 1'b0;
        case (state_q)
            RUN: begin
                if (cand != sel_idx) begin
                    state_d     = DRAIN;
                    pend_d      = cand;
                    cnt_d       = CNT_RELOAD;
                    switching_d = 1'b1;
                end else begin
                    load_bus = 1'b1;
                end
            end
            DRAIN: begin
                if ((cand != pend_q) && !multi) begin
                    pend_d = cand;
                    cnt_d  = CNT_RELOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    sel_d       = pend_q;
                    switching_d = 1'b0;
                    state_d     = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pend_q     <= '0;
            cnt_q      <= '0;
            sel_idx    <= '0;
            switching  <= 1'b0;
            onehot_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            sel_idx    <= sel_d;
            switching  <= switching_d;
            onehot_err <= onehot_err | multi;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            di         <= DI_IDLE;
            irq_n      <= IRQ_N_IDLE;
            rom_addr   <= '0;
            rom_ce_n   <= ROM_CE_N_IDLE;
            rom_oe_n   <= ROM_OE_N_IDLE;
            rom_word   <= ROM_WORD_IDLE;
            bsram_addr <= '0;
            bsram_d    <= BSRAM_D_IDLE;
            bsram_ce_n <= BSRAM_CE_N_IDLE;
            bsram_oe_n <= BSRAM_OE_N_IDLE;
            bsram_we_n <= BSRAM_WE_N_IDLE;
        end else if (load_bus) begin
            di         <= sel_do;
            irq_n      <= sel_irq_n;
            rom_addr   <= sel_rom_addr;
            rom_ce_n   <= sel_rom_ce_n;
            rom_oe_n   <= sel_rom_oe_n;
            rom_word   <= sel_rom_word;
            bsram_addr <= sel_bsram_addr;
            bsram_d    <= sel_bsram_d;
            bsram_ce_n <= sel_bsram_ce_n;
            bsram_oe_n <= sel_bsram_oe_n;
            bsram_we_n <= sel_bsram_we_n;
        end else begin
            di         <= DI_IDLE;
            irq_n      <= IRQ_N_IDLE;
            rom_addr   <= '0;
            rom_ce_n   <= ROM_CE_N_IDLE;
            rom_oe_n   <= ROM_OE_N_IDLE;
            rom_word   <= ROM_WORD_IDLE;
            bsram_addr <= '0;
            bsram_d    <= BSRAM_D_IDLE;
            bsram_ce_n <= BSRAM_CE_N_IDLE;
            bsram_oe_n <= BSRAM_OE_N_IDLE;
            bsram_we_n <= BSRAM_WE_N_IDLE;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_map_bus_arbiter.sv
// Directed bench for map_bus_arbiter: a vector table of map_active sequences with
// hand-computed bus ownership, plus hand-written reset and signal-follow sequences.
module tb_map_bus_arbiter;
    import map_bus_pkg::*;

    localparam int NUM_MAP   = 4;
    localparam int ROM_AW    = 23;
    localparam int BSRAM_AW  = 20;
    localparam int DRAIN_CYC = 4;
    localparam int NCH       = NUM_MAP + 1;
    localparam int IDLE      = -1;

    logic                            mclk;
    logic                            rst_n;
    logic [NUM_MAP-1:0]              map_active;
    logic [8*NCH-1:0]                ch_do;
    logic [NUM_MAP:0]                ch_irq_n;
    logic [ROM_AW*NCH-1:0]           ch_rom_addr;
    logic [NUM_MAP:0]                ch_rom_ce_n;
    logic [NUM_MAP:0]                ch_rom_oe_n;
    logic [NUM_MAP:0]                ch_rom_word;
    logic [BSRAM_AW*NCH-1:0]         ch_bsram_addr;
    logic [8*NCH-1:0]                ch_bsram_d;
    logic [NUM_MAP:0]                ch_bsram_ce_n;
    logic [NUM_MAP:0]                ch_bsram_oe_n;
    logic [NUM_MAP:0]                ch_bsram_we_n;
    logic [7:0]                      di;
    logic                            irq_n;
    logic [ROM_AW-1:0]               rom_addr;
    logic                            rom_ce_n;
    logic                            rom_oe_n;
    logic                            rom_word;
    logic [BSRAM_AW-1:0]             bsram_addr;
    logic [7:0]                      bsram_d;
    logic                            bsram_ce_n;
    logic                            bsram_oe_n;
    logic                            bsram_we_n;
    logic [2:0]                      sel_idx;
    logic                            switching;
    logic                            onehot_err;
    arb_state_e                      dbg_state;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [7:0]          di_v [NCH];
    logic [ROM_AW-1:0]   ra_v [NCH];
    logic [BSRAM_AW-1:0] ba_v [NCH];
    logic [7:0]          bd_v [NCH];

    typedef struct {
        logic [3:0] map;
        int         ch;
        int         sel;
        bit         sw;
        bit         err;
    } vec_t;

    vec_t vq[$];

    map_bus_arbiter #(
        .NUM_MAP   (NUM_MAP),
        .ROM_AW    (ROM_AW),
        .BSRAM_AW  (BSRAM_AW),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .mclk          (mclk),
        .rst_n         (rst_n),
        .map_active    (map_active),
        .ch_do         (ch_do),
        .ch_irq_n      (ch_irq_n),
        .ch_rom_addr   (ch_rom_addr),
        .ch_rom_ce_n   (ch_rom_ce_n),
        .ch_rom_oe_n   (ch_rom_oe_n),
        .ch_rom_word   (ch_rom_word),
        .ch_bsram_addr (ch_bsram_addr),
        .ch_bsram_d    (ch_bsram_d),
        .ch_bsram_ce_n (ch_bsram_ce_n),
        .ch_bsram_oe_n (ch_bsram_oe_n),
        .ch_bsram_we_n (ch_bsram_we_n),
        .di            (di),
        .irq_n         (irq_n),
        .rom_addr      (rom_addr),
        .rom_ce_n      (rom_ce_n),
        .rom_oe_n      (rom_oe_n),
        .rom_word      (rom_word),
        .bsram_addr    (bsram_addr),
        .bsram_d       (bsram_d),
        .bsram_ce_n    (bsram_ce_n),
        .bsram_oe_n    (bsram_oe_n),
        .bsram_we_n    (bsram_we_n),
        .sel_idx       (sel_idx),
        .switching     (switching),
        .onehot_err    (onehot_err),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // ch is the channel expected on the buses, or IDLE for idle values.
    task automatic check(input string name, input int ch, input int sel, input bit sw, input bit err);
        logic [7:0]          e_di;
        logic [ROM_AW-1:0]   e_ra;
        logic [BSRAM_AW-1:0] e_ba;
        logic [7:0]          e_bd;
        logic                e_ce, e_oe, e_word;
        arb_state_e          e_st;
        e_di   = (ch < 0) ? 8'h00 : di_v[ch];
        e_ra   = (ch < 0) ? '0 : ra_v[ch];
        e_ba   = (ch < 0) ? '0 : ba_v[ch];
        e_bd   = (ch < 0) ? 8'h00 : bd_v[ch];
        e_ce   = (ch < 0);
        e_oe   = (ch < 0);
        e_word = (ch >= 0);
        e_st   = sw ? DRAIN : RUN;
        vec_cnt++;
        if (di !== e_di || rom_addr !== e_ra || rom_ce_n !== e_ce || rom_oe_n !== e_oe ||
            rom_word !== e_word || bsram_addr !== e_ba || bsram_d !== e_bd ||
            bsram_ce_n !== e_ce || bsram_oe_n !== e_oe || sel_idx !== 3'(sel) ||
            switching !== sw || onehot_err !== err || dbg_state !== e_st) begin
            miss_cnt++;
            $display("FAIL %s: got di=%h rom_addr=%h rom_ce_n=%b rom_word=%b bsram_addr=%h sel=%0d sw=%b err=%b st=%0d, want di=%h rom_addr=%h rom_ce_n=%b rom_word=%b bsram_addr=%h sel=%0d sw=%b err=%b",
                     name, di, rom_addr, rom_ce_n, rom_word, bsram_addr, sel_idx, switching, onehot_err,
                     dbg_state, e_di, e_ra, e_ce, e_word, e_ba, sel, sw, err);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] map, input int ch, input int sel, input bit sw, input bit err);
        vec_t v;
        v.map = map; v.ch = ch; v.sel = sel; v.sw = sw; v.err = err;
        vq.push_back(v);
    endtask

    task automatic tick;
        @(posedge mclk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        map_active    = '0;
        ra_v          = '{23'h000100, 23'h011111, 23'h022222, 23'h123456, 23'h044444};
        for (int c = 0; c < NCH; c++) begin
            di_v[c] = 8'hA0 + 8'(c);
            bd_v[c] = 8'h50 + 8'(c);
            ba_v[c] = 20'h10000 * 20'(c) + 20'h00321;
            ch_do[8*c +: 8]                   = di_v[c];
            ch_bsram_d[8*c +: 8]              = bd_v[c];
            ch_rom_addr[ROM_AW*c +: ROM_AW]   = ra_v[c];
            ch_bsram_addr[BSRAM_AW*c +: BSRAM_AW] = ba_v[c];
        end
        ch_irq_n      = '1;
        ch_rom_ce_n   = '0;
        ch_rom_oe_n   = '0;
        ch_rom_word   = '1;
        ch_bsram_ce_n = '0;
        ch_bsram_oe_n = '0;
        ch_bsram_we_n = '1;

        repeat (3) @(posedge mclk);
        #1;
        check("in_reset", IDLE, 0, 0, 0);
        @(negedge mclk);
        rst_n = 1'b1;
        #1;
        check("release_before_clk", IDLE, 0, 0, 0);
        tick();
        check("first_clk_ch0", 0, 0, 0, 0);

        // switch 0 -> 3
        add(4'b0000, 0,    0, 0, 0);
        add(4'b0100, IDLE, 0, 1, 0);
        add(4'b0100, IDLE, 0, 1, 0);
        add(4'b0100, IDLE, 0, 1, 0);
        add(4'b0100, IDLE, 0, 1, 0);
        add(4'b0100, IDLE, 3, 0, 0);
        add(4'b0100, 3,    3, 0, 0);
        add(4'b0100, 3,    3, 0, 0);
        // request ch1, redirect to ch4 two cycles into the drain
        add(4'b0001, IDLE, 3, 1, 0);
        add(4'b0001, IDLE, 3, 1, 0);
        add(4'b1000, IDLE, 3, 1, 0);
        add(4'b1000, IDLE, 3, 1, 0);
        add(4'b1000, IDLE, 3, 1, 0);
        add(4'b1000, IDLE, 3, 1, 0);
        add(4'b1000, IDLE, 4, 0, 0);
        add(4'b1000, 4,    4, 0, 0);
        // back to ch0
        add(4'b0000, IDLE, 4, 1, 0);
        add(4'b0000, IDLE, 4, 1, 0);
        add(4'b0000, IDLE, 4, 1, 0);
        add(4'b0000, IDLE, 4, 1, 0);
        add(4'b0000, IDLE, 0, 0, 0);
        add(4'b0000, 0,    0, 0, 0);
        // multiple active in RUN: no switch, sticky error
        add(4'b0011, 0,    0, 0, 1);
        add(4'b0000, 0,    0, 0, 1);
        // multiple active during DRAIN: counter continues
        add(4'b0010, IDLE, 0, 1, 1);
        add(4'b0110, IDLE, 0, 1, 1);
        add(4'b0010, IDLE, 0, 1, 1);
        add(4'b0010, IDLE, 0, 1, 1);
        add(4'b0010, IDLE, 2, 0, 1);
        add(4'b0010, 2,    2, 0, 1);
        // leave ch2 then return to it mid-drain: drain still completes
        add(4'b0000, IDLE, 2, 1, 1);
        add(4'b0010, IDLE, 2, 1, 1);
        add(4'b0010, IDLE, 2, 1, 1);
        add(4'b0010, IDLE, 2, 1, 1);
        add(4'b0010, IDLE, 2, 1, 1);
        add(4'b0010, IDLE, 2, 0, 1);
        add(4'b0010, 2,    2, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            map_active = vq[i].map;
            tick();
            check($sformatf("vec%0d", i), vq[i].ch, vq[i].sel, vq[i].sw, vq[i].err);
        end

        // ch2 owns the bus: only its irq/we changes reach the outputs, one cycle later
        ch_irq_n[2] = 1'b0;
        #1;
        check_bit("irq_not_early", irq_n, 1'b1);
        tick();
        check_bit("irq_follow_low", irq_n, 1'b0);
        check_bit("we_idle_a", bsram_we_n, 1'b1);
        ch_irq_n[1] = 1'b0;
        ch_irq_n[2] = 1'b1;
        ch_bsram_we_n[4] = 1'b0;
        tick();
        check_bit("irq_follow_high", irq_n, 1'b1);
        check_bit("we_other_ignored", bsram_we_n, 1'b1);
        ch_bsram_we_n[2] = 1'b0;
        #1;
        check_bit("we_not_early", bsram_we_n, 1'b1);
        tick();
        check_bit("we_follow_low", bsram_we_n, 1'b0);
        check_bit("irq_other_ignored", irq_n, 1'b1);
        ch_bsram_we_n[2] = 1'b1;
        tick();
        check_bit("we_follow_high", bsram_we_n, 1'b1);
        ch_irq_n      = '1;
        ch_bsram_we_n = '1;

        // reset on the second DRAIN cycle loses the pending ch3 selection
        map_active = 4'b0100;
        tick();
        check("rst_drain1", IDLE, 2, 1, 1);
        tick();
        check("rst_drain2", IDLE, 2, 1, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async", IDLE, 0, 0, 0);
        map_active = 4'b0000;
        @(negedge mclk);
        rst_n = 1'b1;
        tick();
        check("rst_after_ch0", 0, 0, 0, 0);
        repeat (5) tick();
        check("rst_pend_lost", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
